multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM that sequences a multi-cycle MIPS datapath sharing one memory port for fetch and data.
//  Decodes IR opcode/funct and drives all mux selects, write strobes and the memory request handshake.
//  Supports addu, subu, ori, lui, lw, sw, beq, j, jal and jr.
//  Traps on an illegal opcode/funct or on a memory timeout.
// PARAMETERS
//  TIMEOUT  255  max cycles MemReq may stay high without MemReady before trapping (1..255, 8-bit counter)
// PORTS
//  Clk       in   1  single clock, all state updates on rising edge
//  Reset     in   1  synchronous, active-high
//  OpCode    in   6  IR[31:26] (IR register output)
//  Funct     in   6  IR[5:0]
//  Zero      in   1  ALU zero flag
//  MemReady  in   1  memory completes current request this cycle
//  MemReq    out  1  memory request; held until MemReady
//  MemWrite  out  1  request is a write (only with MemReq)
//  IorD      out  1  mem address: 0=PC, 1=ALUOut
//  IRWrite   out  1  load IR and memory-data register
//  PCWrite   out  1  load PC from PCSource mux
//  PCSource  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],2'b00}, 3=busA
//  RegWrite  out  1  GRF write enable
//  RegDst    out  2  0=rd, 1=rt, 2=5'd31
//  RegSrc    out  2  0=ALUOut, 1=memory-data register, 2=PC
//  ALUSrcA   out  1  0=PC, 1=busA
//  ALUSrcB   out  2  0=busB, 1=32'd4, 2=ext imm, 3=ext imm<<2
//  ALUCtr    out  4  0=add, 1=sub, 2=or, 3=lui (B<<16)
//  ExtOp     out  1  1=sign-extend, 0=zero-extend
//  State     out  3  current state, for debug
//  Trap      out  1  sticky trap flag
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 BRANCH=5 JUMP=6 TRAP=7.
//  Outputs are decoded combinationally from State, OpCode/Funct and MemReady.
//  Reset: State<=FETCH, timeout count<=0, Trap<=0; while Reset=1 all strobes (MemReq, MemWrite, IRWrite, PCWrite, RegWrite) read 0.
//  Reset mid-operation aborts the instruction; no strobe is issued in the Reset cycle.
//  Unlisted selects default to 0 in every state.
//  FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUCtr=add, PCSource=0.
//    IRWrite=PCWrite=1 only in the cycle MemReady=1; then ->DECODE, else stay.
//  DECODE: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUCtr=add (branch target into ALUOut).
//    Next state: beq->BRANCH; j/jal/jr->JUMP; illegal->TRAP; all others->EXEC.
//  EXEC: ALUSrcA=1. R-type: ALUSrcB=0, ALUCtr add/sub.
//    ori: ALUSrcB=2, ExtOp=0, or. lui: ALUSrcB=2, ExtOp=0, lui.
//    lw/sw: ALUSrcB=2, ExtOp=1, add.
//    Next state: lw/sw->MEM, else ->WB.
//  MEM: MemReq=1, IorD=1, MemWrite=(sw).
//    lw: IRWrite stays 0 (memory-data register load via separate MDR enable = MemReq&MemReady&IorD).
//    On MemReady: lw->WB, sw->FETCH.
//  WB: RegWrite=1. R-type: RegDst=0, RegSrc=0. ori/lui: RegDst=1, RegSrc=0. lw: RegDst=1, RegSrc=1. Always ->FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=0, ALUCtr=sub, PCSource=1, PCWrite=Zero; ->FETCH.
//  JUMP: PCWrite=1; PCSource=2 for j/jal, 3 for jr.
//    jal additionally RegWrite=1, RegDst=2, RegSrc=2 (PC already PC+4). ->FETCH.
//  Timeout: count increments each FETCH/MEM cycle with MemReady=0; cleared on MemReady or state change.
//    Count reaching TIMEOUT with MemReady still 0 -> TRAP next edge.
//    MemReady in the same cycle as the limit wins: completes normally.
//  TRAP: all strobes 0, Trap=1, stays until Reset.
//  Cycle counts at MemReady=1: ALU ops 4, lw 5, sw 4, beq 3, j/jal/jr 3.
// TESTING
//  Reset 2 cycles then MemReady=1 -> State=FETCH, Trap=0, strobes 0 during Reset; MemReq=1 and IRWrite=PCWrite=1 in the first cycle after.
//  addu (op 0, funct 0x21), MemReady=1 -> states 0,1,2,4; RegWrite=1 with RegDst=0 in cycle 4.
//  lw (op 0x23), MemReady low 3 cycles in MEM -> MEM held 4 cycles, MemWrite=0, IorD=1; then WB with RegSrc=1, RegDst=1.
//  beq (op 0x04): Zero=1 -> PCWrite=1, PCSource=1 in BRANCH; Zero=0 -> PCWrite=0.
//  jal (op 0x03) -> JUMP with PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, RegSrc=2.
//  TIMEOUT=4, MemReady stuck 0 in FETCH -> TRAP after 4 cycles, Trap=1 sticky; opcode 0x3F -> TRAP from DECODE.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/memory handshake bundle between the multi-cycle MIPS controller and its datapath
interface multicycle_controller_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] RegSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUCtr;
    logic       ExtOp;
    logic [2:0] State;
    logic       Trap;

    modport master (
        input  OpCode, Funct, Zero, MemReady,
        output MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSource, RegWrite,
               RegDst, RegSrc, ALUSrcA, ALUSrcB, ALUCtr, ExtOp, State, Trap
    );

    modport slave (
        output OpCode, Funct, Zero, MemReady,
        input  MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSource, RegWrite,
               RegDst, RegSrc, ALUSrcA, ALUSrcB, ALUCtr, ExtOp, State, Trap
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM with shared memory port and timeout trap
module multicycle_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic                          Clk,
    input  logic                          Reset,
    multicycle_controller_if.master       bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        JUMP   = 3'd6,
        TRAP   = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       trap_q;

    logic op_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, legal;
    logic mem_phase, timed_out;

    logic       mem_req, mem_write, iord, ir_write, pc_write, reg_write;
    logic       alu_src_a, ext_op;
    logic [1:0] pc_source, reg_dst, reg_src, alu_src_b;
    logic [3:0] alu_ctr;

    assign op_r    = (bus.OpCode == 6'h00);
    assign is_addu = op_r && (bus.Funct == 6'h21);
    assign is_subu = op_r && (bus.Funct == 6'h23);
    assign is_jr   = op_r && (bus.Funct == 6'h08);
    assign is_ori  = (bus.OpCode == 6'h0D);
    assign is_lui  = (bus.OpCode == 6'h0F);
    assign is_lw   = (bus.OpCode == 6'h23);
    assign is_sw   = (bus.OpCode == 6'h2B);
    assign is_beq  = (bus.OpCode == 6'h04);
    assign is_j    = (bus.OpCode == 6'h02);
    assign is_jal  = (bus.OpCode == 6'h03);
    assign legal   = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw
                   | is_beq | is_j | is_jal;

    // The wait that would bring the count up to TIMEOUT traps, unless MemReady arrives in that same cycle.
    assign mem_phase = (state_q == FETCH) || (state_q == MEM);
    assign timed_out = mem_phase && !bus.MemReady && (wait_q == WAIT_LIMIT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= FETCH;
            wait_q  <= 8'd0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= (state_d == TRAP);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (bus.MemReady)  state_d = DECODE;
                else if (timed_out) state_d = TRAP;
            end
            DECODE: begin
                if (!legal)                    state_d = TRAP;
                else if (is_beq)               state_d = BRANCH;
                else if (is_j | is_jal | is_jr) state_d = JUMP;
                else                           state_d = EXEC;
            end
            EXEC:   state_d = (is_lw | is_sw) ? MEM : WB;
            MEM: begin
                if (bus.MemReady)   state_d = is_sw ? FETCH : WB;
                else if (timed_out) state_d = TRAP;
            end
            WB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = TRAP;
        endcase

        wait_d = (mem_phase && !bus.MemReady && (state_d == state_q)) ? wait_q + 8'd1 : 8'd0;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        pc_source = 2'd0;
        reg_dst   = 2'd0;
        reg_src   = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_ctr   = 4'd0;
        ext_op    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                ext_op    = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                if (is_ori) begin
                    alu_src_b = 2'd2;
                    alu_ctr   = 4'd2;
                end else if (is_lui) begin
                    alu_src_b = 2'd2;
                    alu_ctr   = 4'd3;
                end else if (is_lw | is_sw) begin
                    alu_src_b = 2'd2;
                    ext_op    = 1'b1;
                end else if (is_subu) begin
                    alu_ctr   = 4'd1;
                end
            end
            MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = is_sw;
            end
            WB: begin
                reg_write = 1'b1;
                if (is_lw) begin
                    reg_dst = 2'd1;
                    reg_src = 2'd1;
                end else if (is_ori | is_lui) begin
                    reg_dst = 2'd1;
                end
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctr   = 4'd1;
                pc_source = 2'd1;
                pc_write  = bus.Zero;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = is_jr ? 2'd3 : 2'd2;
                if (is_jal) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd2;
                    reg_src   = 2'd2;
                end
            end
            default: ;
        endcase
        // Reset aborts the instruction without letting any strobe escape in that cycle.
        if (Reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign bus.MemReq   = mem_req;
    assign bus.MemWrite = mem_write;
    assign bus.IorD     = iord;
    assign bus.IRWrite  = ir_write;
    assign bus.PCWrite  = pc_write;
    assign bus.PCSource = pc_source;
    assign bus.RegWrite = reg_write;
    assign bus.RegDst   = reg_dst;
    assign bus.RegSrc   = reg_src;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUCtr   = alu_ctr;
    assign bus.ExtOp    = ext_op;
    assign bus.State    = state_q;
    assign bus.Trap     = trap_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller driven by per-instruction cycle traces
module tb_multicycle_controller;
    localparam int TIMEOUT = 4;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    multicycle_controller_if bus();

    multicycle_controller #(.TIMEOUT(TIMEOUT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       mreq;
        logic       mwr;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] rsrc;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] ctr;
        logic       ext;
        logic       trap;
        logic       strobes_only;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t fetch_rec(input logic rdy);
        exp_t e = blank(3'd0);
        e.mreq = 1'b1;
        e.asb  = 2'd1;
        e.irw  = rdy;
        e.pcw  = rdy;
        return e;
    endfunction

    function automatic exp_t reset_rec();
        exp_t e = fetch_rec(1'b0);
        e.mreq = 1'b0;
        return e;
    endfunction

    function automatic exp_t decode_rec();
        exp_t e = blank(3'd1);
        e.asb = 2'd3;
        e.ext = 1'b1;
        return e;
    endfunction

    function automatic exp_t exec_rec(input logic [5:0] op, input logic [5:0] fn);
        exp_t e = blank(3'd2);
        e.asa = 1'b1;
        if (op == 6'h0D) begin e.asb = 2'd2; e.ctr = 4'd2; end
        else if (op == 6'h0F) begin e.asb = 2'd2; e.ctr = 4'd3; end
        else if (op == 6'h23 || op == 6'h2B) begin e.asb = 2'd2; e.ext = 1'b1; end
        else if (fn == 6'h23) e.ctr = 4'd1;
        return e;
    endfunction

    function automatic exp_t mem_rec(input logic is_store);
        exp_t e = blank(3'd3);
        e.mreq = 1'b1;
        e.iord = 1'b1;
        e.mwr  = is_store;
        return e;
    endfunction

    function automatic exp_t wb_rec(input logic [5:0] op);
        exp_t e = blank(3'd4);
        e.rw = 1'b1;
        if (op == 6'h23) begin e.rdst = 2'd1; e.rsrc = 2'd1; end
        else if (op != 6'h00) e.rdst = 2'd1;
        return e;
    endfunction

    function automatic exp_t branch_rec(input logic z);
        exp_t e = blank(3'd5);
        e.asa = 1'b1;
        e.ctr = 4'd1;
        e.pcs = 2'd1;
        e.pcw = z;
        return e;
    endfunction

    function automatic exp_t jump_rec(input logic [5:0] op);
        exp_t e = blank(3'd6);
        e.pcw = 1'b1;
        e.pcs = (op == 6'h00) ? 2'd3 : 2'd2;
        if (op == 6'h03) begin e.rw = 1'b1; e.rdst = 2'd2; e.rsrc = 2'd2; end
        return e;
    endfunction

    function automatic exp_t trap_rec();
        exp_t e = blank(3'd7);
        e.trap = 1'b1;
        return e;
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h21) || (fn == 6'h23) || (fn == 6'h08);
        return (op == 6'h0D) || (op == 6'h0F) || (op == 6'h23) || (op == 6'h2B)
            || (op == 6'h04) || (op == 6'h02) || (op == 6'h03);
    endfunction

    task automatic step(input exp_t e, input logic rdy, input logic z, input logic rst);
        Reset        = rst;
        bus.MemReady = rdy;
        bus.Zero     = z;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        exp_t e = blank(3'd0);
        e.strobes_only = 1'b1;
        step(e, rb(), rb(), 1'b1);
        for (int i = 1; i < n; i++) step(reset_rec(), rb(), rb(), 1'b1);
    endtask

    task automatic do_trap();
        int n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) step(trap_rec(), rb(), rb(), 1'b0);
        do_reset($urandom_range(1, 2));
    endtask

    // Whole instruction as a cycle trace: fetch waits, decode, then the class-specific tail.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z, input logic abort);
        bus.OpCode = op;
        bus.Funct  = fn;
        for (int i = 0; i < fw && i < TIMEOUT; i++) step(fetch_rec(1'b0), 1'b0, rb(), 1'b0);
        if (fw >= TIMEOUT) begin do_trap(); return; end
        step(fetch_rec(1'b1), 1'b1, rb(), 1'b0);
        step(decode_rec(), rb(), rb(), 1'b0);
        if (abort) begin do_reset(1); return; end
        if (!is_legal(op, fn)) begin do_trap(); return; end
        if (op == 6'h04) begin step(branch_rec(z), rb(), z, 1'b0); return; end
        if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08)) begin
            step(jump_rec(op), rb(), rb(), 1'b0);
            return;
        end
        step(exec_rec(op, fn), rb(), rb(), 1'b0);
        if (op == 6'h23 || op == 6'h2B) begin
            for (int i = 0; i < mw && i < TIMEOUT; i++) step(mem_rec(op == 6'h2B), 1'b0, rb(), 1'b0);
            if (mw >= TIMEOUT) begin do_trap(); return; end
            step(mem_rec(op == 6'h2B), 1'b1, rb(), 1'b0);
            if (op == 6'h2B) return;
        end
        step(wb_rec(op), rb(), rb(), 1'b0);
    endtask

    initial begin : monitor
        exp_t e, a, m;
        logic ok;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: bus.State, mreq: bus.MemReq, mwr: bus.MemWrite, iord: bus.IorD,
                      irw: bus.IRWrite, pcw: bus.PCWrite, pcs: bus.PCSource, rw: bus.RegWrite,
                      rdst: bus.RegDst, rsrc: bus.RegSrc, asa: bus.ALUSrcA, asb: bus.ALUSrcB,
                      ctr: bus.ALUCtr, ext: bus.ExtOp, trap: bus.Trap, strobes_only: 1'b0};
                if (e.strobes_only) begin
                    ok = ({a.mreq, a.mwr, a.irw, a.pcw, a.rw} === {e.mreq, e.mwr, e.irw, e.pcw, e.rw});
                end else begin
                    ok = (a === e);
                end
                total++;
                if (!ok) begin
                    bad++;
                    m = e;
                    m.strobes_only = 1'b0;
                    $display("FAIL cycle%0d%s got=%h required=%h", cyc,
                             e.strobes_only ? "_reset_strobes" : "_outputs", a, m);
                end
                cyc++;
            end
        end
    end

    initial begin : stimulus
        logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
        logic [5:0] fns [10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
        Reset        = 1'b1;
        bus.MemReady = 1'b1;
        bus.Zero     = 1'b0;
        bus.OpCode   = 6'h00;
        bus.Funct    = 6'h21;
        @(posedge Clk);
        #1;
        do_reset(2);
        run_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0);
        run_instr(6'h04, 6'h00, 1, 0, 1'b1, 1'b0);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h2B, 6'h00, 3, 3, 1'b0, 1'b0);
        run_instr(6'h00, 6'h21, 9, 0, 1'b0, 1'b0);
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h23, 6'h00, 0, 6, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            int         k  = $urandom_range(0, 11);
            int         fw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            int         mw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            logic       ab = ($urandom_range(0, 11) == 0);
            logic [5:0] op, fn;
            if (k < 10) begin
                op = ops[k];
                fn = (op == 6'h00) ? fns[k] : 6'($urandom_range(0, 63));
            end else if (k == 10) begin
                op = 6'($urandom_range(1, 63));
                while (is_legal(op, 6'h00)) op = 6'($urandom_range(1, 63));
                fn = 6'($urandom_range(0, 63));
            end else begin
                op = 6'h00;
                fn = 6'($urandom_range(0, 63));
                while (is_legal(op, fn)) fn = 6'($urandom_range(0, 63));
            end
            run_instr(op, fn, fw, mw, rb(), ab);
        end

        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
